// File: rtl/sva_stim_gen_pkg.sv
// Shared types and beat helpers for the sva_stim_gen stimulus generator.
// Property under test: a ##1 d[*1:3] ##1 e, vacuous when !a.
package sva_stim_pkg;

  typedef enum logic [1:0] {
    KIND_PASS = 2'd0,
    KIND_FAIL = 2'd1,
    KIND_VAC  = 2'd2,
    KIND_RSVD = 2'd3
  } stim_kind_t;

  typedef enum logic [1:0] {
    V_LAZY   = 2'd0,
    V_SUCC   = 2'd1,
    V_FAIL   = 2'd2,
    V_BADCMD = 2'd3
  } verdict_t;

  typedef enum logic [1:0] {
    RST_HOLD = 2'd0,
    IDLE     = 2'd1,
    ARMED    = 2'd2,
    BEAT     = 2'd3
  } gen_state_t;

  typedef struct packed {
    logic a;
    logic d;
    logic e;
  } beat_t;

  function automatic logic [2:0] rep_of(logic [1:0] drep);
    return (drep == 2'd0) ? 3'd1 : {1'b0, drep};
  endfunction

  function automatic logic [2:0] stage_of(
    logic [2:0] rep,
    logic [2:0] stage
  );
    logic [2:0] lim;
    lim = rep + 3'd1;
    return (stage == 3'd0 || stage > lim) ? lim : stage;
  endfunction

  function automatic logic [2:0] last_of(
    stim_kind_t kind,
    logic [2:0] rep,
    logic [2:0] stage
  );
    logic [2:0] l;
    l = 3'd0;
    unique case (kind)
      KIND_PASS: l = rep + 3'd1;
      KIND_FAIL: l = stage;
      default:   l = 3'd0;
    endcase
    return l;
  endfunction

  // FAIL follows the PASS pattern up to the cut beat, which is all-zero
  function automatic beat_t beat_of(
    stim_kind_t kind,
    logic [2:0] rep,
    logic [2:0] stage,
    logic [2:0] idx
  );
    beat_t b;
    logic  cut;
    b   = '0;
    cut = (kind == KIND_FAIL) && (idx == stage);
    if (kind == KIND_PASS || kind == KIND_FAIL) begin
      unique case (1'b1)
        cut:                              b   = '0;
        !cut && idx == 3'd0:              b.a = 1'b1;
        !cut && idx != 3'd0 && idx <= rep: b.d = 1'b1;
        !cut && idx != 3'd0 && idx > rep:  b.e = 1'b1;
      endcase
    end
    return b;
  endfunction

  function automatic verdict_t verdict_of(stim_kind_t kind);
    verdict_t v;
    v = V_BADCMD;
    unique case (kind)
      KIND_PASS: v = V_SUCC;
      KIND_FAIL: v = V_FAIL;
      KIND_VAC:  v = V_LAZY;
      default:   v = V_BADCMD;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/sva_stim_gen_if.sv
// Command handshake and verdict bundle of sva_stim_gen.
// master = command source / verdict sink, slave = generator.
interface sva_stim_gen_if;
  import sva_stim_pkg::*;

  logic       cmd_valid;
  logic       cmd_ready;
  stim_kind_t cmd_kind;
  logic [1:0] cmd_drep;
  logic [2:0] cmd_fail_stage;
  logic       exp_valid;
  verdict_t   exp_code;

  modport master (
    output cmd_valid,
    output cmd_kind,
    output cmd_drep,
    output cmd_fail_stage,
    input  cmd_ready,
    input  exp_valid,
    input  exp_code
  );

  modport slave (
    input  cmd_valid,
    input  cmd_kind,
    input  cmd_drep,
    input  cmd_fail_stage,
    output cmd_ready,
    output exp_valid,
    output exp_code
  );

endinterface

// File: rtl/sva_stim_gen_gclk_gen.sv
// User clock divider and user reset hold for sva_stim_gen.
// Ticks mark the sys_clk cycle at whose end gclk toggles.
module gclk_gen #(
  parameter int HALF_PERIOD = 4,
  parameter int GRST_CYCLES = 2
) (
  input  logic sys_clk,
  input  logic sys_rst,
  output logic gclk,
  output logic grst,
  output logic fall_tick,
  output logic rise_tick
);

  localparam int CW = $clog2(HALF_PERIOD);
  localparam int RW = $clog2(GRST_CYCLES + 1);

  logic [CW-1:0] cnt;
  logic [RW-1:0] rcnt;
  logic          wrap;
  logic          held;

  assign wrap      = (cnt == CW'(HALF_PERIOD - 1));
  assign fall_tick = wrap & gclk;
  assign rise_tick = wrap & ~gclk;
  assign held      = (rcnt == RW'(GRST_CYCLES));

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      cnt  <= '0;
      gclk <= 1'b0;
      rcnt <= '0;
      grst <= 1'b1;
    end else begin
      cnt <= wrap ? '0 : cnt + 1'b1;
      if (wrap) gclk <= ~gclk;
      if (rise_tick && !held) rcnt <= rcnt + 1'b1;
      // release on a falling edge so grst is stable at the next rise
      if (fall_tick && held) grst <= 1'b0;
    end
  end

endmodule

// File: rtl/sva_stim_gen.sv
// Stimulus generator for gclk-domain sequence checkers: drives a/d/e
// one gclk beat at a time and reports the verdict a checker must give.
module sva_stim_gen
  import sva_stim_pkg::*;
#(
  parameter int HALF_PERIOD = 4,
  parameter int GRST_CYCLES = 2
) (
  input  logic           sys_clk,
  input  logic           sys_rst,
  sva_stim_gen_if.slave  cmd,
  output logic           gclk,
  output logic           grst,
  output logic           a,
  output logic           d,
  output logic           e,
  output logic           busy
);

  gen_state_t state;
  gen_state_t state_nxt;
  stim_kind_t kind_q;
  verdict_t   verd_q;
  beat_t      beat_q;
  logic [2:0] rep_q;
  logic [2:0] stage_q;
  logic [2:0] last_q;
  logic [2:0] idx_q;
  logic [2:0] rep_in;
  logic [2:0] stage_in;
  logic       pend_q;
  logic       fall_tick;
  logic       hs;
  logic       last_beat;

  gclk_gen #(
    .HALF_PERIOD (HALF_PERIOD),
    .GRST_CYCLES (GRST_CYCLES)
  ) u_gclk (
    .sys_clk   (sys_clk),
    .sys_rst   (sys_rst),
    .gclk      (gclk),
    .grst      (grst),
    .fall_tick (fall_tick),
    .rise_tick ()
  );

  assign hs        = cmd.cmd_valid & cmd.cmd_ready;
  assign rep_in    = rep_of(cmd.cmd_drep);
  assign stage_in  = stage_of(rep_in, cmd.cmd_fail_stage);
  assign last_beat = (idx_q == last_q);
  assign a         = beat_q.a;
  assign d         = beat_q.d;
  assign e         = beat_q.e;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) state <= RST_HOLD;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      RST_HOLD: if (!grst) state_nxt = IDLE;
      IDLE: begin
        if (hs && cmd.cmd_kind != KIND_RSVD)
          state_nxt = ARMED;
      end
      ARMED: if (fall_tick) state_nxt = BEAT;
      BEAT:  if (fall_tick && last_beat) state_nxt = IDLE;
    endcase
  end

  // hold off a new command while the previous verdict is still pending
  always_comb begin
    cmd.cmd_ready = (state == IDLE) && !pend_q;
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      kind_q        <= KIND_PASS;
      verd_q        <= V_LAZY;
      beat_q        <= '0;
      rep_q         <= 3'd1;
      stage_q       <= 3'd0;
      last_q        <= 3'd0;
      idx_q         <= 3'd0;
      pend_q        <= 1'b0;
      busy          <= 1'b0;
      cmd.exp_valid <= 1'b0;
      cmd.exp_code  <= V_LAZY;
    end else begin
      cmd.exp_valid <= pend_q;
      pend_q        <= 1'b0;
      if (pend_q) begin
        cmd.exp_code <= verd_q;
        busy         <= 1'b0;
      end
      unique case (state)
        IDLE: begin
          if (hs) begin
            kind_q  <= cmd.cmd_kind;
            rep_q   <= rep_in;
            stage_q <= stage_in;
            last_q  <= last_of(cmd.cmd_kind, rep_in, stage_in);
            verd_q  <= verdict_of(cmd.cmd_kind);
            if (cmd.cmd_kind == KIND_RSVD) begin
              cmd.exp_valid <= 1'b1;
              cmd.exp_code  <= V_BADCMD;
            end else begin
              busy <= 1'b1;
            end
          end
        end
        ARMED: begin
          if (fall_tick) begin
            idx_q  <= 3'd0;
            beat_q <= beat_of(kind_q, rep_q, stage_q, 3'd0);
          end
        end
        BEAT: begin
          if (fall_tick) begin
            if (last_beat) begin
              beat_q <= '0;
              pend_q <= 1'b1;
            end else begin
              idx_q  <= idx_q + 3'd1;
              beat_q <= beat_of(kind_q, rep_q, stage_q, idx_q + 3'd1);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
